key_event_gen: RTL and testbench

KEY_EVENT_GEN -- requirements
Module: key_event_gen

---
 rtl/key_event_gen.sv | 224 ++++++++++++++++++++++
 tb/tb_key_event_gen.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_gen.sv
// Turns raw switches and buttons into one-at-a-time calculator events on a valid/ready port.
// Define KEY_DEBOUNCE_EN to debounce each input group; otherwise the synchronizer feeds events directly.
module key_event_gen #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] btn,
    input  logic [4:0] opcode,
    input  logic       clr,
    output logic       evt_valid,
    output logic [1:0] evt_type,
    output logic [9:0] evt_data,
    input  logic       evt_ready
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

    localparam logic [1:0] TYPE_NONE  = 2'b00;
    localparam logic [1:0] TYPE_NUM   = 2'b01;
    localparam logic [1:0] TYPE_OP    = 2'b10;
    localparam logic [1:0] TYPE_CLR   = 2'b11;

    // Lowest set bit selects the operator, so overlapping presses resolve deterministically.
    function automatic logic [2:0] encode_op(input logic [4:0] op);
        logic [2:0] code;
        code = 3'd0;
        if (op[0])      code = 3'd1;
        else if (op[1]) code = 3'd2;
        else if (op[2]) code = 3'd3;
        else if (op[3]) code = 3'd4;
        else if (op[4]) code = 3'd5;
        return code;
    endfunction

    // Bit layout of the raw/synchronized/debounced vectors: {clr, opcode, btn}.
    logic [15:0] sync_meta_d, sync_meta_q;
    logic [15:0] sync_d, sync_q;
    logic [15:0] deb_d, deb_q;

    always_comb begin
        sync_meta_d = {clr, opcode, btn};
        sync_d      = sync_meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
        end else begin
            sync_meta_q <= sync_meta_d;
            sync_q      <= sync_d;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [15:0]   last_d, last_q;
    logic [CW-1:0] cnt_btn_d, cnt_btn_q;
    logic [CW-1:0] cnt_op_d, cnt_op_q;
    logic [CW-1:0] cnt_clr_d, cnt_clr_q;

    // A group is accepted only once its counter has saturated with no change in between.
    always_comb begin
        last_d    = sync_q;
        deb_d     = deb_q;
        cnt_btn_d = cnt_btn_q;
        cnt_op_d  = cnt_op_q;
        cnt_clr_d = cnt_clr_q;

        if (sync_q[9:0] != last_q[9:0])
            cnt_btn_d = '0;
        else if (cnt_btn_q == CNT_MAX)
            deb_d[9:0] = sync_q[9:0];
        else
            cnt_btn_d = cnt_btn_q + 1'b1;

        if (sync_q[14:10] != last_q[14:10])
            cnt_op_d = '0;
        else if (cnt_op_q == CNT_MAX)
            deb_d[14:10] = sync_q[14:10];
        else
            cnt_op_d = cnt_op_q + 1'b1;

        if (sync_q[15] != last_q[15])
            cnt_clr_d = '0;
        else if (cnt_clr_q == CNT_MAX)
            deb_d[15] = sync_q[15];
        else
            cnt_clr_d = cnt_clr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= '0;
            cnt_btn_q <= '0;
            cnt_op_q  <= '0;
            cnt_clr_q <= '0;
        end else begin
            last_q    <= last_d;
            cnt_btn_q <= cnt_btn_d;
            cnt_op_q  <= cnt_op_d;
            cnt_clr_q <= cnt_clr_d;
        end
    end
`else
    always_comb begin
        deb_d = sync_q;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) deb_q <= '0;
        else        deb_q <= deb_d;
    end

    logic [9:0] committed_d, committed_q;
    logic [4:0] op_prev_d, op_prev_q;
    logic       clr_prev_d, clr_prev_q;
    logic [2:0] op_code_d, op_code_q;
    logic       num_new, op_new, clr_new;

    always_comb begin
        committed_d = deb_q[9:0];
        op_prev_d   = deb_q[14:10];
        clr_prev_d  = deb_q[15];
        num_new     = (deb_q[9:0] != committed_q);
        op_new      = (op_prev_q == 5'd0) && (deb_q[14:10] != 5'd0);
        clr_new     = deb_q[15] && !clr_prev_q;
        op_code_d   = op_new ? encode_op(deb_q[14:10]) : op_code_q;
    end

    logic [0:0] state_d, state_q;
    logic [1:0] evt_type_d, evt_type_q;
    logic [9:0] evt_data_d, evt_data_q;
    logic       pend_num_d, pend_num_q;
    logic       pend_op_d, pend_op_q;
    logic       pend_clr_d, pend_clr_q;
    logic       load, take_num, take_op, take_clr, any_pend;

    always_comb begin
        state_d    = state_q;
        evt_type_d = evt_type_q;
        evt_data_d = evt_data_q;
        load       = 1'b0;
        take_num   = 1'b0;
        take_op    = 1'b0;
        take_clr   = 1'b0;
        any_pend   = pend_clr_q | pend_op_q | pend_num_q;

        case (state_q)
            ST_IDLE: begin
                if (any_pend) load = 1'b1;
            end
            default: begin
                if (evt_ready) begin
                    if (any_pend) begin
                        load = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        evt_type_d = TYPE_NONE;
                        evt_data_d = '0;
                    end
                end
            end
        endcase

        if (load) begin
            state_d = ST_PRESENT;
            if (pend_clr_q) begin
                take_clr   = 1'b1;
                evt_type_d = TYPE_CLR;
                evt_data_d = '0;
            end else if (pend_op_q) begin
                take_op    = 1'b1;
                evt_type_d = TYPE_OP;
                evt_data_d = {7'd0, op_code_q};
            end else begin
                take_num   = 1'b1;
                evt_type_d = TYPE_NUM;
                evt_data_d = committed_q;
            end
        end

        // A fresh detection wins over the clear-on-load, so an update racing a load is not lost.
        pend_clr_d = clr_new | (pend_clr_q & ~take_clr);
        pend_op_d  = ~clr_new & (op_new | (pend_op_q & ~take_op));
        pend_num_d = ~clr_new & (num_new | (pend_num_q & ~take_num));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            committed_q <= '0;
            op_prev_q   <= '0;
            clr_prev_q  <= 1'b0;
            op_code_q   <= '0;
            state_q     <= ST_IDLE;
            evt_type_q  <= TYPE_NONE;
            evt_data_q  <= '0;
            pend_num_q  <= 1'b0;
            pend_op_q   <= 1'b0;
            pend_clr_q  <= 1'b0;
        end else begin
            committed_q <= committed_d;
            op_prev_q   <= op_prev_d;
            clr_prev_q  <= clr_prev_d;
            op_code_q   <= op_code_d;
            state_q     <= state_d;
            evt_type_q  <= evt_type_d;
            evt_data_q  <= evt_data_d;
            pend_num_q  <= pend_num_d;
            pend_op_q   <= pend_op_d;
            pend_clr_q  <= pend_clr_d;
        end
    end

    assign evt_valid = (state_q == ST_PRESENT);
    assign evt_type  = evt_type_q;
    assign evt_data  = evt_data_q;

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen: reset, number/operator/clear events, priority, back-to-back and reset abort.
module tb_key_event_gen;

    localparam int DC = 4;
`ifdef KEY_DEBOUNCE_EN
    localparam int LAT = DC + 4;
`else
    localparam int LAT = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] btn;
    logic [4:0] opcode;
    logic       clr;
    logic       evt_valid;
    logic [1:0] evt_type;
    logic [9:0] evt_data;
    logic       evt_ready;

    int tests_run = 0;
    int tests_failed = 0;

    int         cyc = 0;
    int         ev_n = 0;
    logic [1:0] ev_type [256];
    logic [9:0] ev_data [256];
    int         ev_cyc  [256];

    key_event_gen #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .opcode    (opcode),
        .clr       (clr),
        .evt_valid (evt_valid),
        .evt_type  (evt_type),
        .evt_data  (evt_data),
        .evt_ready (evt_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && evt_valid && evt_ready && ev_n < 256) begin
            ev_type[ev_n] = evt_type;
            ev_data[ev_n] = evt_data;
            ev_cyc[ev_n]  = cyc;
            ev_n = ev_n + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn = '0; opcode = '0; clr = 1'b0; evt_ready = 1'b1;
        tick(3);
        tests_run++;
        if ({evt_valid, evt_type, evt_data} !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b t=%0d d=%0d expected all 0", evt_valid, evt_type, evt_data);
        end
    endtask

    task automatic test_number_after_reset();
        int base;
        btn = 10'd37;
        tick(1);
        rst_n = 1'b1;
        base = ev_n;
        tick(LAT);
        tests_run++;
        if (evt_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL num_early: valid got %b expected 0 one cycle before latency", evt_valid);
        end
        tick(1);
        tests_run++;
        if (evt_valid !== 1'b1 || evt_type !== 2'b01 || evt_data !== 10'd37) begin
            tests_failed++;
            $display("FAIL num_latency: got v=%b t=%0d d=%0d expected v=1 t=1 d=37", evt_valid, evt_type, evt_data);
        end
        tick(1);
        tests_run++;
        if (evt_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL num_drop: valid got %b expected 0 after accept", evt_valid);
        end
        tick(30);
        tests_run++;
        if (ev_n - base !== 1) begin
            tests_failed++;
            $display("FAIL num_count: got %0d events expected 1", ev_n - base);
        end
    endtask

    task automatic test_operator();
        int base;
        base = ev_n;
        opcode = 5'b00100;
        tick(10);
        opcode = 5'b00000;
        tick(30);
        tests_run++;
        if (ev_n - base !== 1) begin
            tests_failed++;
            $display("FAIL op_count: got %0d events expected 1", ev_n - base);
        end else begin
            tests_run++;
            if (ev_type[base] !== 2'b10 || ev_data[base] !== 10'd3) begin
                tests_failed++;
                $display("FAIL op_event: got t=%0d d=%0d expected t=2 d=3", ev_type[base], ev_data[base]);
            end
        end
    endtask

    task automatic test_glitch();
        int base;
        base = ev_n;
        btn = 10'd5;
        tick(25);
        tests_run++;
        if (ev_n - base !== 1 || ev_type[base] !== 2'b01 || ev_data[base] !== 10'd5) begin
            tests_failed++;
            $display("FAIL num5_event: got n=%0d t=%0d d=%0d expected n=1 t=1 d=5",
                     ev_n - base, ev_type[base], ev_data[base]);
        end
`ifdef KEY_DEBOUNCE_EN
        base = ev_n;
        btn = 10'd6;
        tick(2);
        btn = 10'd5;
        tick(3);
        opcode = 5'b00010;
        tick(2);
        opcode = 5'b00000;
        tick(25);
        tests_run++;
        if (ev_n - base !== 0) begin
            tests_failed++;
            $display("FAIL glitch_filtered: got %0d events expected 0", ev_n - base);
        end
`endif
    endtask

    task automatic test_priority_hold();
        int base;
        logic [12:0] held;
        evt_ready = 1'b0;
        base = ev_n;
        opcode = 5'b00001; btn = 10'd12; clr = 1'b1;
        tick(LAT + 1);
        held = {evt_valid, evt_type, evt_data};
        tests_run++;
        if (held !== {1'b1, 2'b11, 10'd0}) begin
            tests_failed++;
            $display("FAIL clr_present: got v=%b t=%0d d=%0d expected v=1 t=3 d=0", evt_valid, evt_type, evt_data);
        end
        tick(3);
        tests_run++;
        if ({evt_valid, evt_type, evt_data} !== {1'b1, 2'b11, 10'd0}) begin
            tests_failed++;
            $display("FAIL clr_stable: got v=%b t=%0d d=%0d expected v=1 t=3 d=0", evt_valid, evt_type, evt_data);
        end
        evt_ready = 1'b1;
        tick(1);
        tests_run++;
        if (evt_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_drop: valid got %b expected 0", evt_valid);
        end
        tick(20);
        tests_run++;
        if (ev_n - base !== 1 || ev_type[base] !== 2'b11) begin
            tests_failed++;
            $display("FAIL clr_only: got n=%0d t=%0d expected n=1 t=3", ev_n - base, ev_type[base]);
        end
        opcode = 5'b00000; clr = 1'b0;
        tick(25);
        tests_run++;
        if (ev_n - base !== 1) begin
            tests_failed++;
            $display("FAIL release_silent: got %0d events expected 1", ev_n - base);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        evt_ready = 1'b0;
        clr = 1'b1;
        tick(LAT + 1);
        tests_run++;
        if (evt_valid !== 1'b1 || evt_type !== 2'b11) begin
            tests_failed++;
            $display("FAIL b2b_hold: got v=%b t=%0d expected v=1 t=3", evt_valid, evt_type);
        end
        btn = 10'd9;
        tick(12);
        btn = 10'd14;
        tick(12);
        opcode = 5'b01000;
        tick(12);
        base = ev_n;
        evt_ready = 1'b1;
        tick(6);
        tests_run++;
        if (ev_n - base !== 3) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d events expected 3", ev_n - base);
        end else begin
            tests_run++;
            if (ev_type[base] !== 2'b11 || ev_data[base] !== 10'd0) begin
                tests_failed++;
                $display("FAIL b2b_first: got t=%0d d=%0d expected t=3 d=0", ev_type[base], ev_data[base]);
            end
            tests_run++;
            if (ev_type[base+1] !== 2'b10 || ev_data[base+1] !== 10'd4) begin
                tests_failed++;
                $display("FAIL b2b_op: got t=%0d d=%0d expected t=2 d=4", ev_type[base+1], ev_data[base+1]);
            end
            tests_run++;
            if (ev_type[base+2] !== 2'b01 || ev_data[base+2] !== 10'd14) begin
                tests_failed++;
                $display("FAIL b2b_num: got t=%0d d=%0d expected t=1 d=14", ev_type[base+2], ev_data[base+2]);
            end
            tests_run++;
            if (ev_cyc[base+1] - ev_cyc[base] !== 1 || ev_cyc[base+2] - ev_cyc[base+1] !== 1) begin
                tests_failed++;
                $display("FAIL b2b_spacing: got gaps %0d,%0d expected 1,1",
                         ev_cyc[base+1] - ev_cyc[base], ev_cyc[base+2] - ev_cyc[base+1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        opcode = 5'b00000; clr = 1'b0; evt_ready = 1'b1;
        tick(25);
        evt_ready = 1'b0;
        opcode = 5'b00010;
        tick(LAT + 1);
        tests_run++;
        if (evt_valid !== 1'b1 || evt_type !== 2'b10 || evt_data !== 10'd2) begin
            tests_failed++;
            $display("FAIL sub_present: got v=%b t=%0d d=%0d expected v=1 t=2 d=2", evt_valid, evt_type, evt_data);
        end
        opcode = 5'b00000;
        tick(2);
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({evt_valid, evt_type, evt_data} !== 13'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got v=%b t=%0d d=%0d expected all 0", evt_valid, evt_type, evt_data);
        end
        tick(2);
        evt_ready = 1'b1;
        rst_n = 1'b1;
        base = ev_n;
        tick(LAT + 1);
        tests_run++;
        if (evt_valid !== 1'b1 || evt_type !== 2'b01 || evt_data !== 10'd14) begin
            tests_failed++;
            $display("FAIL post_reset_num: got v=%b t=%0d d=%0d expected v=1 t=1 d=14", evt_valid, evt_type, evt_data);
        end
        tick(30);
        tests_run++;
        if (ev_n - base !== 1) begin
            tests_failed++;
            $display("FAIL post_reset_count: got %0d events expected 1", ev_n - base);
        end
    endtask

    initial begin
        test_reset();
        test_number_after_reset();
        test_operator();
        test_glitch();
        test_priority_hold();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
